// File: rtl/bin16_to_bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (double-dabble, one bit per clock).
// A start/busy/done handshake frames each conversion; blank flags leading zeros.
module bin16_to_bcd_seq #(
    parameter bit BLANK_EN = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd,
    output logic [4:0]  blank
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] shreg;
    logic [19:0] scratch;
    logic [3:0]  cnt;
    logic [19:0] adjusted;
    logic [19:0] shifted;
    logic        accept;
    logic        last_iter;

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake decode
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_iter  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 4'd15) begin
                    last_iter  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    // Add-3 adjust of every digit >= 5 on the pre-shift scratch, then shift in next bit
    always_comb begin
        adjusted = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end else begin
                adjusted[4*i +: 4] = scratch[4*i +: 4];
            end
        end
        shifted = {adjusted[18:0], shreg[15]};
    end

    // Datapath: operand capture, iteration, and result/done registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                shreg   <= bin;
                scratch <= '0;
                cnt     <= '0;
            end else if (busy) begin
                shreg   <= {shreg[14:0], 1'b0};
                scratch <= shifted;
                cnt     <= cnt + 4'd1;
                if (last_iter) begin
                    bcd  <= shifted;
                    done <= 1'b1;
                end
            end
        end
    end

    // Leading-zero blanking: a digit blanks when it and all higher digits are zero
    always_comb begin
        blank = '0;
        if (BLANK_EN) begin
            blank[4] = (bcd[19:16] == 4'd0);
            blank[3] = blank[4] && (bcd[15:12] == 4'd0);
            blank[2] = blank[3] && (bcd[11:8] == 4'd0);
            blank[1] = blank[2] && (bcd[7:4] == 4'd0);
            blank[0] = 1'b0;
        end
    end

endmodule

// File: tb/tb_bin16_to_bcd_seq.sv
// Directed self-checking bench for bin16_to_bcd_seq.
module tb_bin16_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] bin;
    logic        busy, done;
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        busy2, done2;
    logic [19:0] bcd2;
    logic [4:0]  blank2;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bin16_to_bcd_seq #(.BLANK_EN(1'b1)) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .blank(blank)
    );

    bin16_to_bcd_seq #(.BLANK_EN(1'b0)) dut_nb (
        .CLOCK_50(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy2), .done(done2), .bcd(bcd2), .blank(blank2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Count edges until done rises; 40 means the bound expired.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            step();
            lat++;
            if (done) break;
        end
    endtask

    task automatic convert(input string tag, input logic [15:0] v,
                           input logic [19:0] exp_bcd, input logic [4:0] exp_blank);
        int lat;
        bin   = v;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy_after_accept"}, 20'(busy), 20'd1);
        wait_done(lat);
        chk({tag, "_latency"}, 20'(lat), 20'd16);
        chk({tag, "_bcd"}, bcd, exp_bcd);
        chk({tag, "_blank"}, 20'(blank), 20'(exp_blank));
        chk({tag, "_busy_in_done"}, 20'(busy), 20'd0);
        step();
        chk({tag, "_done_one_cycle"}, 20'(done), 20'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) step();
        chk("rst_busy", 20'(busy), 20'd0);
        chk("rst_done", 20'(done), 20'd0);
        chk("rst_bcd", bcd, 20'h00000);
        chk("rst_blank", 20'(blank), 20'(5'b11110));
        chk("rst_blank_nb", 20'(blank2), 20'(5'b00000));
        reset = 1'b0;
        step();

        convert("zero", 16'd0, 20'h00000, 5'b11110);
        convert("max", 16'd65535, 20'h65535, 5'b00000);
        convert("sq255", 16'hFE01, 20'h65025, 5'b00000);

        // Back-to-back with start held high
        bin   = 16'd12345;
        start = 1'b1;
        step();
        bin = 16'd7;
        wait_done(lat);
        chk("b2b1_latency", 20'(lat), 20'd16);
        chk("b2b1_bcd", bcd, 20'h12345);
        chk("b2b1_blank", 20'(blank), 20'(5'b00000));
        wait_done(lat);
        start = 1'b0;
        chk("b2b2_period", 20'(lat), 20'd17);
        chk("b2b2_bcd", bcd, 20'h00007);
        chk("b2b2_blank", 20'(blank), 20'(5'b11110));
        step();
        chk("b2b2_idle", 20'(busy), 20'd0);

        // start pulses while busy are ignored, bin changes do not disturb
        bin   = 16'd1000;
        start = 1'b1;
        step();
        start = 1'b0;
        bin   = 16'd42;
        ndone = 0;
        for (int i = 1; i <= 40; i++) begin
            start = (i == 3 || i == 8 || i == 15);
            step();
            if (done) begin
                ndone++;
                chk("ign_bcd", bcd, 20'h01000);
                chk("ign_blank", 20'(blank), 20'(5'b10000));
                chk("ign_latency", 20'(i), 20'd16);
            end
        end
        start = 1'b0;
        chk("ign_done_count", 20'(ndone), 20'd1);

        // Reset mid-conversion aborts
        bin   = 16'd500;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("abort_busy_before", 20'(busy), 20'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", 20'(busy), 20'd0);
        chk("abort_done", 20'(done), 20'd0);
        chk("abort_bcd", bcd, 20'h00000);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) ndone++;
        end
        chk("abort_no_done", 20'(ndone), 20'd0);
        convert("after_abort", 16'd500, 20'h00500, 5'b11000);

        // BLANK_EN=0 instance runs in lockstep
        bin   = 16'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(lat);
        chk("nb_latency", 20'(lat), 20'd16);
        chk("nb_done", 20'(done2), 20'd1);
        chk("nb_bcd", bcd2, 20'h00009);
        chk("nb_blank", 20'(blank2), 20'(5'b00000));
        chk("nb_ref_blank", 20'(blank), 20'(5'b11110));
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
